// File: rtl/aip_slave_ctrl.sv
// ---------------------------------------------------------------------------
// aip_slave_ctrl
//
// Core-side end of the AIP host bus. The host drives aip_config together with
// read/write/start strobes; this block turns them into accesses to an input
// data memory (host writes, core reads), an output data memory (core writes,
// host reads), a bank of configuration registers, STATUS/ID registers and an
// interrupt line. The attached core sees its own memory ports plus a
// start/done handshake.
//
// Ports
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   aip_dataIn        : host write data
//   aip_config        : register/memory selector
//   aip_read          : host read strobe (level)
//   aip_write         : host write strobe (level)
//   aip_start         : host start strobe (level)
//   aip_dataOut       : registered host read data
//   aip_int           : registered interrupt request
//   core_start        : one-cycle start pulse to the core
//   core_done         : one-cycle completion strobe from the core
//   int_set           : per-source interrupt set strobes from the core
//   core_rd_addr/data : core read port of the input memory (1-cycle latency)
//   core_wr_en/addr/data : core write port of the output memory
//   conf_regs         : flattened configuration bank, register k at [32k+31:32k]
// ---------------------------------------------------------------------------
module aip_slave_ctrl #(
   parameter logic [31:0] IP_ID   = 32'h0000_1001,
   parameter int          MEM_AW  = 4,
   parameter int          CONF_AW = 2,
   parameter int          NUM_INT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   aip_dataIn,
   input  logic [4:0]                    aip_config,
   input  logic                          aip_read,
   input  logic                          aip_write,
   input  logic                          aip_start,
   output logic [31:0]                   aip_dataOut,
   output logic                          aip_int,
   output logic                          core_start,
   input  logic                          core_done,
   input  logic [NUM_INT-1:0]            int_set,
   input  logic [MEM_AW-1:0]             core_rd_addr,
   output logic [31:0]                   core_rd_data,
   input  logic                          core_wr_en,
   input  logic [MEM_AW-1:0]             core_wr_addr,
   input  logic [31:0]                   core_wr_data,
   output logic [32*(2**CONF_AW)-1:0]    conf_regs
);

   localparam int MEM_DEPTH  = 2 ** MEM_AW;
   localparam int CONF_DEPTH = 2 ** CONF_AW;

   localparam logic [4:0] CFG_MDATAIN      = 5'd0;
   localparam logic [4:0] CFG_MDATAIN_PTR  = 5'd1;
   localparam logic [4:0] CFG_MDATAOUT     = 5'd2;
   localparam logic [4:0] CFG_MDATAOUT_PTR = 5'd3;
   localparam logic [4:0] CFG_CONF         = 5'd4;
   localparam logic [4:0] CFG_CONF_PTR     = 5'd5;
   localparam logic [4:0] CFG_STATUS       = 5'd30;
   localparam logic [4:0] CFG_ID           = 5'd31;

   // Host-side input registers and their one-cycle-delayed copies for edge detection
   logic [31:0]         dataIn_q;
   logic [4:0]          config_q;
   logic                read_q, readDly_q;
   logic                write_q, writeDly_q;
   logic                start_q, startDly_q;

   // Pointers, configuration bank, status state
   logic [MEM_AW-1:0]   inPtr_q, inPtr_d;
   logic [MEM_AW-1:0]   outPtr_q, outPtr_d;
   logic [CONF_AW-1:0]  confPtr_q, confPtr_d;
   logic [31:0]         conf_q [CONF_DEPTH];
   logic [NUM_INT-1:0]  flags_q, flags_d;
   logic [NUM_INT-1:0]  enable_q, enable_d;
   logic                busy_q, busy_d;

   // Registered outputs
   logic [31:0]         dataOut_q, dataOut_d;
   logic                int_q, int_d;
   logic                coreStart_q, coreStart_d;
   logic [31:0]         coreRdData_q;

   // Data memories (contents are never reset)
   logic [31:0]         inMem  [MEM_DEPTH];
   logic [31:0]         outMem [MEM_DEPTH];

   // Decoded strobe events
   logic                writeRise, readFall, startRise, startGo;
   logic                inMemWrite, confWrite, statusWrite;
   logic [NUM_INT-1:0]  flagSet, flagClr;

   // Every host strobe, the selector and the data word are registered once.
   // The delayed copies let us act on a single edge per access regardless of
   // how long the host holds a strobe. Clearing the delayed copies on reset
   // makes a strobe that is still high afterwards look like a fresh edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         dataIn_q   <= '0;
         config_q   <= '0;
         read_q     <= 1'b0;
         readDly_q  <= 1'b0;
         write_q    <= 1'b0;
         writeDly_q <= 1'b0;
         start_q    <= 1'b0;
         startDly_q <= 1'b0;
      end else begin
         dataIn_q   <= aip_dataIn;
         config_q   <= aip_config;
         read_q     <= aip_read;
         readDly_q  <= read_q;
         write_q    <= aip_write;
         writeDly_q <= write_q;
         start_q    <= aip_start;
         startDly_q <= start_q;
      end
   end

   // Edge events on the registered strobes and the actions they select.
   // A start is only accepted when idle, and a completion in the same cycle
   // takes priority, so the start is dropped rather than restarting the core.
   always_comb begin
      writeRise   = write_q & ~writeDly_q;
      readFall    = ~read_q & readDly_q;
      startRise   = start_q & ~startDly_q;
      startGo     = startRise & ~busy_q & ~core_done;
      inMemWrite  = writeRise && (config_q == CFG_MDATAIN) && !rst;
      confWrite   = writeRise && (config_q == CFG_CONF);
      statusWrite = writeRise && (config_q == CFG_STATUS);
   end

   // Pointer next-state: data accesses post-increment, pointer writes load the
   // low bits of the data word. Natural binary overflow gives the wrap.
   always_comb begin
      inPtr_d   = inPtr_q;
      outPtr_d  = outPtr_q;
      confPtr_d = confPtr_q;
      if (writeRise) begin
         case (config_q)
            CFG_MDATAIN:      inPtr_d   = inPtr_q + MEM_AW'(1);
            CFG_MDATAIN_PTR:  inPtr_d   = dataIn_q[MEM_AW-1:0];
            CFG_MDATAOUT_PTR: outPtr_d  = dataIn_q[MEM_AW-1:0];
            CFG_CONF:         confPtr_d = confPtr_q + CONF_AW'(1);
            CFG_CONF_PTR:     confPtr_d = dataIn_q[CONF_AW-1:0];
            default: ;
         endcase
      end
      if (readFall && (config_q == CFG_MDATAOUT)) begin
         outPtr_d = outPtr_q + MEM_AW'(1);
      end
   end

   // Status next-state. Sets are OR-ed in after the clear so that a set and a
   // write-1-to-clear of the same flag in one cycle leaves the flag set.
   // core_done is folded into flag 0.
   always_comb begin
      flagSet    = int_set;
      flagSet[0] = int_set[0] | core_done;
      flagClr    = statusWrite ? dataIn_q[NUM_INT-1:0] : '0;
      flags_d    = (flags_q & ~flagClr) | flagSet;
      enable_d   = statusWrite ? dataIn_q[8 +: NUM_INT] : enable_q;
      if (core_done) begin
         busy_d = 1'b0;
      end else if (startGo) begin
         busy_d = 1'b1;
      end else begin
         busy_d = busy_q;
      end
      coreStart_d = startGo;
      int_d       = |(flags_q & enable_q);
   end

   // Host read mux. It runs every cycle from the registered selector, so the
   // output settles two cycles after aip_config and follows a core write to
   // the output memory one cycle later. Data registers that have no read-back
   // meaning return 0; pointer registers return the current pointer.
   always_comb begin
      dataOut_d = '0;
      case (config_q)
         CFG_MDATAIN_PTR:  dataOut_d[MEM_AW-1:0]  = inPtr_q;
         CFG_MDATAOUT:     dataOut_d              = outMem[outPtr_q];
         CFG_MDATAOUT_PTR: dataOut_d[MEM_AW-1:0]  = outPtr_q;
         CFG_CONF_PTR:     dataOut_d[CONF_AW-1:0] = confPtr_q;
         CFG_STATUS: begin
            dataOut_d[NUM_INT-1:0]  = flags_q;
            dataOut_d[8 +: NUM_INT] = enable_q;
            dataOut_d[16]           = busy_q;
         end
         CFG_ID:           dataOut_d              = IP_ID;
         default: ;
      endcase
   end

   // Control state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         inPtr_q      <= '0;
         outPtr_q     <= '0;
         confPtr_q    <= '0;
         flags_q      <= '0;
         enable_q     <= '0;
         busy_q       <= 1'b0;
         dataOut_q    <= '0;
         int_q        <= 1'b0;
         coreStart_q  <= 1'b0;
         coreRdData_q <= '0;
      end else begin
         inPtr_q      <= inPtr_d;
         outPtr_q     <= outPtr_d;
         confPtr_q    <= confPtr_d;
         flags_q      <= flags_d;
         enable_q     <= enable_d;
         busy_q       <= busy_d;
         dataOut_q    <= dataOut_d;
         int_q        <= int_d;
         coreStart_q  <= coreStart_d;
         coreRdData_q <= inMem[core_rd_addr];
      end
   end

   // Configuration bank, cleared by reset and written through the auto-incrementing pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < CONF_DEPTH; k++) begin
            conf_q[k] <= '0;
         end
      end else if (confWrite) begin
         conf_q[confPtr_q] <= dataIn_q;
      end
   end

   // Memory arrays. Nonblocking writes mean a core read of an address that
   // the host writes in the same cycle still returns the old word.
   always_ff @(posedge clk) begin
      if (inMemWrite) begin
         inMem[inPtr_q] <= dataIn_q;
      end
      if (core_wr_en) begin
         outMem[core_wr_addr] <= core_wr_data;
      end
   end

   // Flatten the configuration bank onto the output bus
   always_comb begin
      conf_regs = '0;
      for (int k = 0; k < CONF_DEPTH; k++) begin
         conf_regs[32*k +: 32] = conf_q[k];
      end
   end

   assign aip_dataOut  = dataOut_q;
   assign aip_int      = int_q;
   assign core_start   = coreStart_q;
   assign core_rd_data = coreRdData_q;

endmodule

// File: tb/tb_aip_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aip_slave_ctrl
//
// Directed sequence with randomized data against a behavioural model made of
// plain arrays and counters: the memories, pointers, config bank, flags,
// enable mask and busy bit as the host and core would see them.
// ---------------------------------------------------------------------------
module tb_aip_slave_ctrl;

   localparam int          MEM_AW  = 4;
   localparam int          CONF_AW = 2;
   localparam int          NUM_INT = 8;
   localparam logic [31:0] IP_ID   = 32'h0000_1001;
   localparam int          DEPTH   = 16;
   localparam int          CDEPTH  = 4;

   logic                     clk;
   logic                     rst;
   logic [31:0]              aip_dataIn;
   logic [4:0]               aip_config;
   logic                     aip_read;
   logic                     aip_write;
   logic                     aip_start;
   logic [31:0]              aip_dataOut;
   logic                     aip_int;
   logic                     core_start;
   logic                     core_done;
   logic [NUM_INT-1:0]       int_set;
   logic [MEM_AW-1:0]        core_rd_addr;
   logic [31:0]              core_rd_data;
   logic                     core_wr_en;
   logic [MEM_AW-1:0]        core_wr_addr;
   logic [31:0]              core_wr_data;
   logic [32*CDEPTH-1:0]     conf_regs;

   aip_slave_ctrl #(
      .IP_ID   (IP_ID),
      .MEM_AW  (MEM_AW),
      .CONF_AW (CONF_AW),
      .NUM_INT (NUM_INT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .aip_dataIn   (aip_dataIn),
      .aip_config   (aip_config),
      .aip_read     (aip_read),
      .aip_write    (aip_write),
      .aip_start    (aip_start),
      .aip_dataOut  (aip_dataOut),
      .aip_int      (aip_int),
      .core_start   (core_start),
      .core_done    (core_done),
      .int_set      (int_set),
      .core_rd_addr (core_rd_addr),
      .core_rd_data (core_rd_data),
      .core_wr_en   (core_wr_en),
      .core_wr_addr (core_wr_addr),
      .core_wr_data (core_wr_data),
      .conf_regs    (conf_regs)
   );

   // Behavioural model state
   logic [31:0] mIn  [DEPTH];
   bit          mInValid [DEPTH];
   logic [31:0] mOut [DEPTH];
   logic [31:0] mConf [CDEPTH];
   int          mInPtr, mOutPtr, mConfPtr;
   logic [7:0]  mFlags, mEnable;
   bit          mBusy;

   int checks = 0;
   int errors = 0;
   int startPulses = 0;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count cycles in which core_start is high, sampled on the falling edge
   always @(negedge clk) begin
      if (core_start === 1'b1) startPulses++;
   end

   function automatic logic [31:0] mStatus();
      return {15'b0, mBusy, mEnable, mFlags};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Host write access with a randomly stretched strobe; the model is updated
   // with the effect the access should have once it completes.
   task automatic applyStimulus(input logic [4:0] cfg, input logic [31:0] data);
      tick();
      aip_config = cfg;
      aip_dataIn = data;
      aip_write  = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      aip_write  = 1'b0;
      repeat (3) tick();
      case (cfg)
         5'd0: begin
            mIn[mInPtr] = data;
            mInValid[mInPtr] = 1'b1;
            mInPtr = (mInPtr + 1) % DEPTH;
         end
         5'd1:  mInPtr = int'(data % DEPTH);
         5'd3:  mOutPtr = int'(data % DEPTH);
         5'd4: begin
            mConf[mConfPtr] = data;
            mConfPtr = (mConfPtr + 1) % CDEPTH;
         end
         5'd5:  mConfPtr = int'(data % CDEPTH);
         5'd30: begin
            mFlags  = mFlags & ~data[7:0];
            mEnable = data[15:8];
         end
         default: ;
      endcase
   endtask

   // Host read access held for 'hold' cycles; returns the last sampled word
   task automatic hostRead(input logic [4:0] cfg, input int hold, output logic [31:0] data);
      tick();
      aip_config = cfg;
      aip_read   = 1'b1;
      repeat (hold) tick();
      data     = aip_dataOut;
      aip_read = 1'b0;
      repeat (3) tick();
      if (cfg == 5'd2) mOutPtr = (mOutPtr + 1) % DEPTH;
   endtask

   task automatic coreWrite(input int addr, input logic [31:0] data);
      tick();
      core_wr_en   = 1'b1;
      core_wr_addr = MEM_AW'(addr);
      core_wr_data = data;
      tick();
      core_wr_en   = 1'b0;
      mOut[addr]   = data;
   endtask

   task automatic coreRead(input int addr, output logic [31:0] data);
      tick();
      core_rd_addr = MEM_AW'(addr);
      tick();
      data = core_rd_data;
   endtask

   task automatic modelReset();
      mInPtr = 0; mOutPtr = 0; mConfPtr = 0;
      mFlags = '0; mEnable = '0; mBusy = 1'b0;
      for (int k = 0; k < CDEPTH; k++) mConf[k] = '0;
   endtask

   initial begin : stimulus
      logic [31:0] d;
      logic [31:0] a [4];
      logic [31:0] oldWord, newWord, v;
      int addr;
      logic [7:0] s;

      aip_dataIn = '0; aip_config = '0; aip_read = 1'b0; aip_write = 1'b0;
      aip_start = 1'b0; core_done = 1'b0; int_set = '0; core_rd_addr = '0;
      core_wr_en = 1'b0; core_wr_addr = '0; core_wr_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         mInValid[k] = 1'b0;
         mOut[k] = '0;
      end
      modelReset();

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      checkOutput("rst_dataOut", aip_dataOut, 32'h0);
      checkOutput("rst_int", {31'b0, aip_int}, 32'h0);
      checkOutput("rst_coreStart", {31'b0, core_start}, 32'h0);
      checkOutput("rst_coreRdData", core_rd_data, 32'h0);
      for (int k = 0; k < CDEPTH; k++) checkOutput("rst_conf", conf_regs[32*k +: 32], 32'h0);
      rst = 1'b0;

      hostRead(5'd31, 3, d);
      checkOutput("id", d, IP_ID);
      hostRead(5'd30, 3, d);
      checkOutput("status_init", d, mStatus());
      checkOutput("int_init", {31'b0, aip_int}, 32'h0);
      hostRead(5'd17, 3, d);
      checkOutput("unmapped_read", d, 32'h0);

      // Input memory with pointer wrap
      applyStimulus(5'd1, 32'd14);
      for (int i = 0; i < 4; i++) begin
         a[i] = $urandom;
         applyStimulus(5'd0, a[i]);
      end
      for (int i = 0; i < 4; i++) begin
         coreRead((14 + i) % DEPTH, d);
         checkOutput("inmem_wrap", d, a[i]);
      end
      applyStimulus(5'd1, $urandom);
      for (int i = 0; i < 5; i++) applyStimulus(5'd0, $urandom);
      for (int i = 0; i < 6; i++) begin
         addr = $urandom_range(0, DEPTH - 1);
         while (!mInValid[addr]) addr = (addr + 1) % DEPTH;
         coreRead(addr, d);
         checkOutput("inmem_rand", d, mIn[addr]);
      end

      // Host write and core read of the same input word in one cycle
      applyStimulus(5'd1, 32'd14 | ($urandom & 32'hFFFF_FFF0));
      oldWord = mIn[14];
      newWord = $urandom;
      tick();
      core_rd_addr = 4'd14;
      aip_config = 5'd0; aip_dataIn = newWord; aip_write = 1'b1;
      tick();
      aip_write = 1'b0;
      tick();
      checkOutput("rd_collision_old", core_rd_data, oldWord);
      tick();
      checkOutput("rd_collision_new", core_rd_data, newWord);
      mIn[14] = newWord; mInPtr = 15;

      // Output memory read through the auto-incrementing pointer
      coreWrite(15, 32'd5);
      coreWrite(0, 32'd6);
      for (int i = 1; i < 5; i++) coreWrite(i, $urandom);
      applyStimulus(5'd3, 32'd15);
      hostRead(5'd2, 3, d);
      checkOutput("outmem_first", d, 32'd5);
      hostRead(5'd2, 3, d);
      checkOutput("outmem_wrap", d, 32'd6);
      for (int i = 0; i < 3; i++) begin
         v = mOut[mOutPtr];
         hostRead(5'd2, $urandom_range(2, 4), d);
         checkOutput("outmem_rand", d, v);
      end

      // Core overwrites the word a host read is currently returning
      newWord = $urandom;
      tick();
      aip_config = 5'd2; aip_read = 1'b1;
      tick(); tick();
      core_wr_en = 1'b1; core_wr_addr = MEM_AW'(mOutPtr); core_wr_data = newWord;
      tick();
      core_wr_en = 1'b0;
      tick();
      checkOutput("outmem_bypass", aip_dataOut, newWord);
      aip_read = 1'b0;
      repeat (3) tick();
      mOut[mOutPtr] = newWord;
      mOutPtr = (mOutPtr + 1) % DEPTH;

      // Configuration bank
      applyStimulus(5'd5, $urandom);
      for (int i = 0; i < 6; i++) applyStimulus(5'd4, $urandom);
      for (int k = 0; k < CDEPTH; k++) checkOutput("conf", conf_regs[32*k +: 32], mConf[k]);

      // Start / busy / done
      applyStimulus(5'd30, 32'h0000_0100);
      startPulses = 0;
      tick(); aip_start = 1'b1;
      repeat (5) tick();
      aip_start = 1'b0;
      tick();
      checkOutput("start_pulse", startPulses, 32'd1);
      mBusy = 1'b1;
      hostRead(5'd30, 3, d);
      checkOutput("status_busy", d, mStatus());
      startPulses = 0;
      tick(); aip_start = 1'b1;
      repeat (3) tick();
      aip_start = 1'b0;
      tick();
      checkOutput("start_while_busy", startPulses, 32'd0);
      tick(); core_done = 1'b1;
      tick(); core_done = 1'b0;
      mBusy = 1'b0; mFlags[0] = 1'b1;
      hostRead(5'd30, 3, d);
      checkOutput("status_done", d, 32'h0000_0101);
      checkOutput("int_done", {31'b0, aip_int}, 32'h1);
      applyStimulus(5'd30, 32'h0000_0101);
      hostRead(5'd30, 3, d);
      checkOutput("status_cleared", d, 32'h0000_0100);
      checkOutput("int_cleared", {31'b0, aip_int}, 32'h0);

      // Set and clear of flag 3 in the same cycle
      tick(); int_set = 8'h08;
      tick(); int_set = 8'h00;
      mFlags[3] = 1'b1;
      tick();
      aip_config = 5'd30; aip_dataIn = 32'h0000_0108; aip_write = 1'b1;
      tick();
      aip_write = 1'b0; int_set = 8'h08;
      tick();
      int_set = 8'h00;
      repeat (2) tick();
      mEnable = 8'h01;
      hostRead(5'd30, 3, d);
      checkOutput("set_beats_clear", d, mStatus());

      // Random interrupt sources, clears and enables
      for (int i = 0; i < 4; i++) begin
         s = 8'($urandom_range(1, 255));
         tick(); int_set = s;
         tick(); int_set = 8'h00;
         mFlags = mFlags | s;
         applyStimulus(5'd30, $urandom & 32'h0001_FFFF);
         hostRead(5'd30, 3, d);
         checkOutput("status_rand", d, mStatus());
         checkOutput("int_rand", {31'b0, aip_int}, {31'b0, |(mFlags & mEnable)});
      end

      // core_done and a start edge in the same cycle
      startPulses = 0;
      tick(); aip_start = 1'b1;
      repeat (3) tick();
      aip_start = 1'b0;
      tick();
      checkOutput("start_pulse2", startPulses, 32'd1);
      mBusy = 1'b1;
      startPulses = 0;
      tick(); aip_start = 1'b1;
      tick(); core_done = 1'b1;
      tick(); core_done = 1'b0;
      repeat (2) tick();
      aip_start = 1'b0;
      tick();
      checkOutput("done_beats_start", startPulses, 32'd0);
      mBusy = 1'b0; mFlags[0] = 1'b1;
      hostRead(5'd30, 3, d);
      checkOutput("status_done_start", d, mStatus());

      // Reset in the middle of a read, with conf written and the core busy
      applyStimulus(5'd4, $urandom);
      applyStimulus(5'd4, $urandom);
      tick(); aip_start = 1'b1;
      repeat (3) tick();
      aip_start = 1'b0;
      tick();
      aip_config = 5'd31; aip_read = 1'b1;
      repeat (3) tick();
      checkOutput("midread_id", aip_dataOut, IP_ID);
      rst = 1'b1;
      tick();
      checkOutput("midrst_dataOut", aip_dataOut, 32'h0);
      checkOutput("midrst_int", {31'b0, aip_int}, 32'h0);
      for (int k = 0; k < CDEPTH; k++) checkOutput("midrst_conf", conf_regs[32*k +: 32], 32'h0);
      rst = 1'b0; aip_read = 1'b0;
      tick();
      modelReset();
      hostRead(5'd30, 3, d);
      checkOutput("postrst_status", d, 32'h0);
      v = $urandom;
      applyStimulus(5'd0, v);
      coreRead(0, d);
      checkOutput("postrst_inptr", d, v);
      v = $urandom;
      applyStimulus(5'd4, v);
      checkOutput("postrst_confptr", conf_regs[31:0], v);
      v = mOut[0];
      hostRead(5'd2, 3, d);
      checkOutput("postrst_outptr", d, v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
